pkg_fft_output_run_ctrl: RTL

//  Run controller for the pkg_fft_output HLS core (ap_ctrl_hs).
//  - Issues ap_start, tracks ap_ready/ap_done/ap_idle and re-launches the core while enabled.
//  - Watches per-port AXIS back-pressure; stall >= stall_limit cycles -> latch culprit ports,

---
 rtl/pkg_fft_output_run_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pkg_fft_output_run_ctrl.sv
// Run controller for the pkg_fft_output HLS core (ap_ctrl_hs handshake).
// Relaunches the core while enabled and recovers it from AXIS stalls via a core-local reset.
module pkg_fft_output_run_ctrl #(
    parameter int NUM_AXIS   = 1,
    parameter int CNT_W      = 16,
    parameter int RST_CYCLES = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [CNT_W-1:0]    stall_limit,
    input  logic                stall_clear,
    input  logic [NUM_AXIS-1:0] axis_block,
    input  logic                core_ap_ready,
    input  logic                core_ap_done,
    input  logic                core_ap_idle,
    output logic                core_ap_start,
    output logic                core_rst,
    output logic                busy,
    output logic                stall_flag,
    output logic [NUM_AXIS-1:0] stall_axis,
    output logic [7:0]          restart_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_STALL,
        S_CORE_RST,
        S_DRAIN
    } state_t;

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LAST = RC_W'(RST_CYCLES - 1);

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    stall_cnt_reg, stall_cnt_next;
    logic [RC_W-1:0]     rst_cnt_reg, rst_cnt_next;
    logic                stall_flag_reg;
    logic [NUM_AXIS-1:0] stall_axis_reg, stall_axis_next;
    logic [7:0]          restart_count_reg;

    logic               any_block;
    logic [CNT_W:0]     cnt_plus1;
    logic               trip;

    assign any_block = |axis_block;
    assign cnt_plus1 = {1'b0, stall_cnt_reg} + (CNT_W + 1)'(1);
    // Trip on the stall_limit-th consecutive blocked cycle; a zero limit disables the watchdog.
    assign trip = (state_reg == S_RUN) && any_block && (stall_limit != '0) &&
                  (cnt_plus1 >= {1'b0, stall_limit});

    always_comb begin
        state_next     = state_reg;
        stall_cnt_next = '0;
        rst_cnt_next   = '0;
        case (state_reg)
            S_IDLE: begin
                if (enable)
                    state_next = S_START;
            end
            S_START: begin
                if (core_ap_ready) begin
                    if (core_ap_done)
                        state_next = enable ? S_START : S_IDLE;
                    else
                        state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (any_block)
                    stall_cnt_next = (&stall_cnt_reg) ? stall_cnt_reg
                                                      : stall_cnt_reg + CNT_W'(1);
                if (trip)
                    state_next = S_STALL;
                else if (core_ap_done)
                    state_next = enable ? S_START : S_IDLE;
            end
            S_STALL: begin
                state_next = S_CORE_RST;
            end
            S_CORE_RST: begin
                if (rst_cnt_reg == RST_LAST)
                    state_next = S_DRAIN;
                else
                    rst_cnt_next = rst_cnt_reg + RC_W'(1);
            end
            S_DRAIN: begin
                if (core_ap_idle)
                    state_next = enable ? S_START : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // The trip snapshot is protected from stall_clear until the STALL cycle has passed.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_AXIS; gi++) begin : g_axis
            always_comb begin
                stall_axis_next[gi] = stall_axis_reg[gi];
                if (trip)
                    stall_axis_next[gi] = axis_block[gi];
                else if (stall_clear && (state_reg != S_STALL))
                    stall_axis_next[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            stall_cnt_reg     <= '0;
            rst_cnt_reg       <= '0;
            stall_flag_reg    <= 1'b0;
            stall_axis_reg    <= '0;
            restart_count_reg <= 8'd0;
        end else begin
            state_reg      <= state_next;
            stall_cnt_reg  <= stall_cnt_next;
            rst_cnt_reg    <= rst_cnt_next;
            stall_axis_reg <= stall_axis_next;
            if (state_reg == S_STALL)
                stall_flag_reg <= 1'b1;
            else if (stall_clear)
                stall_flag_reg <= 1'b0;
            if ((state_reg == S_STALL) && (restart_count_reg != 8'hFF))
                restart_count_reg <= restart_count_reg + 8'd1;
        end
    end

    assign core_ap_start = (state_reg == S_START);
    assign core_rst      = (state_reg == S_CORE_RST);
    assign busy          = (state_reg != S_IDLE);
    assign stall_flag    = stall_flag_reg;
    assign stall_axis    = stall_axis_reg;
    assign restart_count = restart_count_reg;

endmodule
